// File: rtl/aes_serial_master_if.sv
// Request/response handshake plus serial link between the AES front-end and its bit-serial cores.
// The master modport is the front-end; the slave modport is the client and core side.
interface aes_serial_master_if #(
    parameter int KEY_BITS = 128
);
    logic                in_valid;
    logic                in_ready;
    logic [127:0]        in_data;
    logic [KEY_BITS-1:0] in_key;
    logic                in_mode;
    logic                out_valid;
    logic                out_ready;
    logic [127:0]        out_data;
    logic                mosi;
    logic                miso;
    logic                cs_enc_n;
    logic                cs_dec_n;

    modport master (
        input  in_valid, in_data, in_key, in_mode, out_ready, miso,
        output in_ready, out_valid, out_data, mosi, cs_enc_n, cs_dec_n
    );

    modport slave (
        output in_valid, in_data, in_key, in_mode, out_ready, miso,
        input  in_ready, out_valid, out_data, mosi, cs_enc_n, cs_dec_n
    );
endinterface

// File: rtl/aes_serial_master.sv
// Serial front-end for the bit-serial AES cores. It shifts {key,data} out LSB first,
// waits for the core, then shifts the 128-bit result in and offers it on a valid/ready port.
module aes_serial_master #(
    parameter int KEY_BITS    = 128,
    parameter int WAIT_CYCLES = 48
) (
    input  logic                  clk,
    input  logic                  rst_n,
    aes_serial_master_if.master   ser_if,
    output logic                  busy
);
    localparam int N       = 128 + KEY_BITS;
    localparam int CNT_MAX = (N > WAIT_CYCLES) ? N : WAIT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] SEND_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RECV_LAST = CNT_W'(127);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_RECV,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [N-1:0]     shreg_q;
    logic [127:0]     out_data_q;
    logic             mosi_q;
    logic             cs_enc_q;
    logic             cs_dec_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    assign cnt_d = cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            out_data_q  <= '0;
            mosi_q      <= 1'b0;
            cs_enc_q    <= 1'b1;
            cs_dec_q    <= 1'b1;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ser_if.in_valid) begin
                        // Frame bit 0 goes straight to mosi; the rest waits in the shifter.
                        state_q    <= S_SEND;
                        cnt_q      <= '0;
                        shreg_q    <= {1'b0, ser_if.in_key, ser_if.in_data[127:1]};
                        mosi_q     <= ser_if.in_data[0];
                        cs_enc_q   <= ser_if.in_mode;
                        cs_dec_q   <= ~ser_if.in_mode;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (cnt_q == SEND_LAST) begin
                        state_q <= S_WAIT;
                        cnt_q   <= '0;
                        mosi_q  <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_d;
                        mosi_q  <= shreg_q[0];
                        shreg_q <= {1'b0, shreg_q[N-1:1]};
                    end
                end
                S_WAIT: begin
                    if (cnt_q == WAIT_LAST) begin
                        state_q <= S_RECV;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_RECV: begin
                    // After 128 right-shifts the first sampled bit lands in out_data[0].
                    out_data_q <= {ser_if.miso, out_data_q[127:1]};
                    if (cnt_q == RECV_LAST) begin
                        state_q     <= S_DONE;
                        cnt_q       <= '0;
                        cs_enc_q    <= 1'b1;
                        cs_dec_q    <= 1'b1;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_DONE: begin
                    if (ser_if.out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ser_if.in_ready  = in_ready_q;
    assign ser_if.out_valid = out_valid_q;
    assign ser_if.out_data  = out_data_q;
    assign ser_if.mosi      = mosi_q;
    assign ser_if.cs_enc_n  = cs_enc_q;
    assign ser_if.cs_dec_n  = cs_dec_q;
    assign busy             = busy_q;
endmodule

// File: tb/tb_aes_serial_master.sv
// Directed bench for aes_serial_master: a 128-bit-key instance (A) and a 256-bit-key instance (B),
// each with a behavioural core model that captures mosi and returns a result on miso.
`timescale 1ns/1ps
module tb_aes_serial_master;
    localparam int W     = 48;
    localparam int A_N   = 256;
    localparam int B_N   = 384;
    localparam int A_TOT = A_N + W + 128;   // 432
    localparam int B_TOT = B_N + W + 128;   // 560

    localparam logic [127:0] D1   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] RES1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] DB   = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] KB   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] D2   = 128'hfedcba98765432100123456789abcdef;
    localparam logic [127:0] K2   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] RBP  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] D3   = 128'h3243f6a8885a308d313198a2e0370734;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy_a, busy_b;
    int   checks = 0;
    int   errors = 0;

    aes_serial_master_if #(.KEY_BITS(128)) ia ();
    aes_serial_master_if #(.KEY_BITS(256)) ib ();

    aes_serial_master #(.KEY_BITS(128), .WAIT_CYCLES(W)) dut_a (
        .clk(clk), .rst_n(rst_n), .ser_if(ia.master), .busy(busy_a)
    );
    aes_serial_master #(.KEY_BITS(256), .WAIT_CYCLES(W)) dut_b (
        .clk(clk), .rst_n(rst_n), .ser_if(ib.master), .busy(busy_b)
    );

    always #5 clk = ~clk;

    // Core model A: cycle index counts clocks since its CS fell; returns a_res (or ~captured data).
    int             a_cyc = 0, a_enc_cnt = 0, a_dec_cnt = 0, a_last_len = 0, a_wait_bad = 0;
    logic [A_N-1:0] a_frame = '0;
    logic [127:0]   a_res = '0;
    logic           a_invert = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            a_cyc   = 0;
            ia.miso = 1'b0;
        end else if (!ia.cs_enc_n || !ia.cs_dec_n) begin
            if (a_cyc < A_N) a_frame[a_cyc] = ia.mosi;
            else if (a_cyc < A_N + W && ia.mosi !== 1'b0) a_wait_bad++;
            if (a_cyc >= A_N + W && a_cyc < A_TOT)
                ia.miso = a_invert ? ~a_frame[a_cyc-A_N-W] : a_res[a_cyc-A_N-W];
            else
                ia.miso = 1'b0;
            if (!ia.cs_enc_n) a_enc_cnt++;
            if (!ia.cs_dec_n) a_dec_cnt++;
            a_cyc++;
        end else begin
            if (a_cyc != 0) a_last_len = a_cyc;
            a_cyc   = 0;
            ia.miso = 1'b0;
        end
    end

    int             b_cyc = 0, b_enc_cnt = 0, b_dec_cnt = 0, b_wait_bad = 0;
    logic [B_N-1:0] b_frame = '0;
    logic [127:0]   b_res = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            b_cyc   = 0;
            ib.miso = 1'b0;
        end else if (!ib.cs_enc_n || !ib.cs_dec_n) begin
            if (b_cyc < B_N) b_frame[b_cyc] = ib.mosi;
            else if (b_cyc < B_N + W && ib.mosi !== 1'b0) b_wait_bad++;
            if (b_cyc >= B_N + W && b_cyc < B_TOT) ib.miso = b_res[b_cyc-B_N-W];
            else ib.miso = 1'b0;
            if (!ib.cs_enc_n) b_enc_cnt++;
            if (!ib.cs_dec_n) b_dec_cnt++;
            b_cyc++;
        end else begin
            b_cyc   = 0;
            ib.miso = 1'b0;
        end
    end

    // Present a request on A and return just after the accept edge, scrambling the inputs.
    task automatic a_start(input logic [127:0] d, input logic [127:0] k, input logic m);
        int n;
        n = 0;
        ia.in_data = d; ia.in_key = k; ia.in_mode = m; ia.in_valid = 1'b1;
        while (ia.in_ready !== 1'b1 && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (n >= 2000) begin errors++; $display("FAIL a_start_timeout: in_ready never high"); end
        @(posedge clk); #1;
        ia.in_valid = 1'b0; ia.in_data = ~d; ia.in_key = ~k; ia.in_mode = ~m;
    endtask

    task automatic a_wait_valid(output int lat);
        lat = 0;
        while (ia.out_valid !== 1'b1 && lat < 3000) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic a_take();
        ia.out_ready = 1'b1;
        @(posedge clk); #1;
        ia.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ia.in_ready, ia.out_valid, ia.mosi, ia.cs_enc_n, ia.cs_dec_n, busy_a} !== 6'b100110) begin
            errors++; $display("FAIL reset_a_ctrl: got %b expected 100110",
                {ia.in_ready, ia.out_valid, ia.mosi, ia.cs_enc_n, ia.cs_dec_n, busy_a});
        end
        checks++;
        if ({ib.in_ready, ib.out_valid, ib.mosi, ib.cs_enc_n, ib.cs_dec_n, busy_b} !== 6'b100110) begin
            errors++; $display("FAIL reset_b_ctrl: got %b expected 100110",
                {ib.in_ready, ib.out_valid, ib.mosi, ib.cs_enc_n, ib.cs_dec_n, busy_b});
        end
        checks++;
        if (ia.out_data !== 128'h0) begin errors++; $display("FAIL reset_a_data: got %h expected 0", ia.out_data); end
        rst_n = 1'b1;
        $display("txn reset: power-on reset released");
    endtask

    task automatic test_frame_order();
        int lat, enc0, dec0, wb0;
        a_res = '0; a_invert = 1'b0;
        enc0 = a_enc_cnt; dec0 = a_dec_cnt; wb0 = a_wait_bad;
        a_start(D1, K1, 1'b0);
        a_wait_valid(lat);
        a_take();
        $display("txn frame: data=%h key=%h latency=%0d", D1, K1, lat);
        checks++;
        if (a_frame[7:0] !== 8'hff) begin errors++; $display("FAIL frame_first_byte: got %h expected ff", a_frame[7:0]); end
        checks++;
        if (a_frame[128] !== 1'b1) begin errors++; $display("FAIL frame_bit128: got %b expected 1", a_frame[128]); end
        checks++;
        if (a_frame[132] !== 1'b0) begin errors++; $display("FAIL frame_bit132: got %b expected 0", a_frame[132]); end
        checks++;
        if (a_frame !== {K1, D1}) begin errors++; $display("FAIL frame_all: got %h expected %h", a_frame, {K1, D1}); end
        checks++;
        if (a_enc_cnt - enc0 != A_TOT) begin errors++; $display("FAIL cs_enc_len: got %0d expected %0d", a_enc_cnt - enc0, A_TOT); end
        checks++;
        if (a_dec_cnt - dec0 != 0) begin errors++; $display("FAIL cs_dec_unused: got %0d expected 0", a_dec_cnt - dec0); end
        checks++;
        if (a_last_len != A_TOT) begin errors++; $display("FAIL cs_low_run: got %0d expected %0d", a_last_len, A_TOT); end
        checks++;
        if (a_wait_bad - wb0 != 0) begin errors++; $display("FAIL wait_mosi: got %0d nonzero bits expected 0", a_wait_bad - wb0); end
    endtask

    task automatic test_loopback();
        int lat;
        a_res = RES1; a_invert = 1'b0;
        a_start(D1, K1, 1'b0);
        a_wait_valid(lat);
        $display("txn loopback: result=%h latency=%0d", ia.out_data, lat);
        checks++;
        if (lat != A_TOT) begin errors++; $display("FAIL loop_latency: got %0d expected %0d", lat, A_TOT); end
        checks++;
        if (ia.out_data !== RES1) begin errors++; $display("FAIL loop_data: got %h expected %h", ia.out_data, RES1); end
        a_take();
        checks++;
        if ({ia.out_valid, ia.in_ready, busy_a} !== 3'b010) begin
            errors++; $display("FAIL loop_release: got %b expected 010", {ia.out_valid, ia.in_ready, busy_a});
        end
    endtask

    task automatic test_abort();
        a_res = RES1;
        a_start(D2, K2, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if ({busy_a, ia.cs_enc_n} !== 2'b10) begin errors++; $display("FAIL abort_midsend: got %b expected 10", {busy_a, ia.cs_enc_n}); end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({ia.in_ready, ia.out_valid, ia.mosi, ia.cs_enc_n, ia.cs_dec_n, busy_a} !== 6'b100110) begin
            errors++; $display("FAIL abort_ctrl: got %b expected 100110",
                {ia.in_ready, ia.out_valid, ia.mosi, ia.cs_enc_n, ia.cs_dec_n, busy_a});
        end
        checks++;
        if (ia.out_data !== 128'h0) begin errors++; $display("FAIL abort_data: got %h expected 0", ia.out_data); end
        $display("txn abort: reset during send");
    endtask

    task automatic test_decrypt();
        int lat, enc0, dec0, wb0;
        b_res = D1;
        enc0 = b_enc_cnt; dec0 = b_dec_cnt; wb0 = b_wait_bad;
        ib.in_data = DB; ib.in_key = KB; ib.in_mode = 1'b1; ib.in_valid = 1'b1;
        #0;
        checks++;
        if (ib.in_ready !== 1'b1) begin errors++; $display("FAIL dec_ready: got %b expected 1", ib.in_ready); end
        @(posedge clk); #1;
        ib.in_valid = 1'b0; ib.in_data = ~DB; ib.in_key = ~KB; ib.in_mode = 1'b0;
        lat = 0;
        while (ib.out_valid !== 1'b1 && lat < 3000) begin @(posedge clk); #1; lat++; end
        $display("txn decrypt: result=%h latency=%0d", ib.out_data, lat);
        checks++;
        if (lat != B_TOT) begin errors++; $display("FAIL dec_latency: got %0d expected %0d", lat, B_TOT); end
        checks++;
        if (ib.out_data !== D1) begin errors++; $display("FAIL dec_data: got %h expected %h", ib.out_data, D1); end
        ib.out_ready = 1'b1;
        @(posedge clk); #1;
        ib.out_ready = 1'b0;
        checks++;
        if (b_frame !== {KB, DB}) begin errors++; $display("FAIL dec_frame: got %h expected %h", b_frame, {KB, DB}); end
        checks++;
        if (b_dec_cnt - dec0 != B_TOT) begin errors++; $display("FAIL dec_cs_len: got %0d expected %0d", b_dec_cnt - dec0, B_TOT); end
        checks++;
        if (b_enc_cnt - enc0 != 0) begin errors++; $display("FAIL dec_cs_enc: got %0d expected 0", b_enc_cnt - enc0); end
        checks++;
        if (b_wait_bad - wb0 != 0) begin errors++; $display("FAIL dec_wait_mosi: got %0d expected 0", b_wait_bad - wb0); end
    endtask

    task automatic test_backpressure();
        int lat;
        a_res = RBP; a_invert = 1'b0;
        a_start(D2, K2, 1'b0);
        a_wait_valid(lat);
        checks++;
        if (lat != A_TOT) begin errors++; $display("FAIL bp_latency: got %0d expected %0d", lat, A_TOT); end
        ia.in_data = D3; ia.in_key = K1; ia.in_mode = 1'b0; ia.in_valid = 1'b1;
        a_res = RES1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({ia.out_valid, ia.in_ready} !== 2'b10 || ia.out_data !== RBP) begin
                errors++; $display("FAIL bp_hold cycle %0d: valid/ready %b data %h expected 10 %h",
                    i, {ia.out_valid, ia.in_ready}, ia.out_data, RBP);
            end
        end
        $display("txn backpressure: result=%h held 20 cycles", ia.out_data);
        a_take();
        checks++;
        if ({ia.out_valid, ia.in_ready, busy_a} !== 3'b010) begin
            errors++; $display("FAIL bp_handshake: got %b expected 010", {ia.out_valid, ia.in_ready, busy_a});
        end
        @(posedge clk); #1;
        ia.in_valid = 1'b0; ia.in_data = ~D3;
        checks++;
        if ({busy_a, ia.in_ready, ia.cs_enc_n} !== 3'b100) begin
            errors++; $display("FAIL bp_next_accept: got %b expected 100", {busy_a, ia.in_ready, ia.cs_enc_n});
        end
        a_wait_valid(lat);
        checks++;
        if (lat != A_TOT) begin errors++; $display("FAIL bp2_latency: got %0d expected %0d", lat, A_TOT); end
        checks++;
        if (ia.out_data !== RES1) begin errors++; $display("FAIL bp2_data: got %h expected %h", ia.out_data, RES1); end
        checks++;
        if (a_frame !== {K1, D3}) begin errors++; $display("FAIL bp2_frame: got %h expected %h", a_frame, {K1, D3}); end
        a_take();
        $display("txn backpressure-next: result=%h", RES1);
    endtask

    task automatic test_back_to_back();
        logic [127:0] ds [3];
        logic [127:0] ks [3];
        logic [127:0] got [3];
        int           acc_edge [3];
        int           edge_n, nacc, nres;
        logic         pre_acc, pre_hs;
        logic [127:0] pre_data;
        ds[0] = D1; ds[1] = D2; ds[2] = D3;
        ks[0] = K1; ks[1] = K2; ks[2] = ~K1;
        edge_n = 0; nacc = 0; nres = 0;
        a_invert = 1'b1;
        ia.in_data = ds[0]; ia.in_key = ks[0]; ia.in_mode = 1'b0;
        ia.in_valid = 1'b1; ia.out_ready = 1'b1;
        while (nres < 3 && edge_n < 3 * 434 + 100) begin
            pre_acc  = ia.in_valid && ia.in_ready;
            pre_hs   = ia.out_valid && ia.out_ready;
            pre_data = ia.out_data;
            @(posedge clk); #1;
            edge_n++;
            if (pre_acc && nacc < 3) begin
                acc_edge[nacc] = edge_n;
                nacc++;
                if (nacc < 3) begin
                    ia.in_data = ds[nacc]; ia.in_key = ks[nacc];
                end else begin
                    ia.in_valid = 1'b0;
                end
            end
            if (pre_hs && nres < 3) begin
                got[nres] = pre_data;
                $display("txn b2b %0d: accepted at edge %0d result=%h", nres, acc_edge[nres], pre_data);
                nres++;
            end
        end
        ia.out_ready = 1'b0;
        ia.in_valid  = 1'b0;
        a_invert     = 1'b0;
        checks++;
        if (nres != 3 || nacc != 3) begin
            errors++; $display("FAIL b2b_count: got %0d accepts %0d results expected 3 3", nacc, nres);
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (acc_edge[i] - acc_edge[i-1] != 434) begin
                    errors++; $display("FAIL b2b_spacing %0d: got %0d expected 434", i, acc_edge[i] - acc_edge[i-1]);
                end
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got[i] !== ~ds[i]) begin
                    errors++; $display("FAIL b2b_data %0d: got %h expected %h", i, got[i], ~ds[i]);
                end
            end
        end
    endtask

    initial begin
        ia.in_valid = 1'b0; ia.in_data = '0; ia.in_key = '0; ia.in_mode = 1'b0; ia.out_ready = 1'b0;
        ib.in_valid = 1'b0; ib.in_data = '0; ib.in_key = '0; ib.in_mode = 1'b0; ib.out_ready = 1'b0;
        test_reset();
        test_frame_order();
        test_loopback();
        test_abort();
        test_decrypt();
        test_backpressure();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
